// File: rtl/escaped_stream_decoder_pkg.sv
// Shared constants and types for the escaped host-command stream decoder.
// Command bytes, escape commands and instruction codes live here.
package escaped_stream_decoder_pkg;

    localparam logic [7:0] HOSTCMD_ESCAPE = 8'hFE;
    localparam logic [7:0] HOSTCMD_RESET  = 8'h02;
    localparam logic [7:0] HOSTCMD_READ   = 8'h10;
    localparam logic [7:0] HOSTCMD_WRITE  = 8'h20;
    localparam logic [7:0] HOSTCMD_STATUS = 8'h30;
    localparam logic [7:0] HOSTCMD_STREAM = 8'h40;

    localparam logic [7:0] ESCAPECMD_IDLE    = 8'h00;
    localparam logic [7:0] ESCAPECMD_ACK     = 8'h01;
    localparam logic [7:0] ESCAPECMD_LITERAL = 8'hFE;

    localparam logic [6:0] ST_IDLE         = 7'h00;
    localparam logic [6:0] INSTRUCTION_ACK = 7'h01;
    localparam logic [6:0] ST_RESET        = 7'h02;
    localparam logic [6:0] ST_READ         = 7'h10;
    localparam logic [6:0] ST_WRITE        = 7'h20;
    localparam logic [6:0] ST_STATUS       = 7'h30;
    localparam logic [6:0] ST_STREAM       = 7'h40;
    localparam logic [6:0] ST_ERROR        = 7'h7F;

    typedef enum logic {
        ESC_CLEAR,
        ESC_ARMED
    } escState_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       idle;
    } inByte_t;

endpackage

// File: rtl/escaped_stream_decoder_cmd_lut.sv
// Host command table: maps a command byte to its instruction code
// and tells whether the command byte itself is also payload.
module escaped_stream_decoder_cmd_lut
    import escaped_stream_decoder_pkg::*;
(
    input  logic [7:0] cmdByte,
    output logic [6:0] instrCode,
    output logic       hasPayload
);

    always_comb begin
        instrCode  = ST_ERROR;
        hasPayload = 1'b0;
        unique case (cmdByte)
            HOSTCMD_RESET:  instrCode = ST_RESET;
            HOSTCMD_READ:   instrCode = ST_READ;
            HOSTCMD_STATUS: instrCode = ST_STATUS;
            HOSTCMD_WRITE: begin
                instrCode  = ST_WRITE;
                hasPayload = 1'b1;
            end
            HOSTCMD_STREAM: begin
                instrCode  = ST_STREAM;
                hasPayload = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/escaped_stream_decoder.sv
// Escaped byte-stream decoder: splits host bytes into instructions and
// payload, packs payload little-endian into words and buffers them.
module escaped_stream_decoder
    import escaped_stream_decoder_pkg::*;
#(
    parameter int BYTES_PER_WORD = 1,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_AW        = 4
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic [7:0]                  iBYTE,
    input  logic                        iBYTE_VALID,
    input  logic                        iDECODER_IDLE_TO_TAKE_COMMAND,
    input  logic                        iDECODER_ACK_INSTR,
    input  logic                        iWORD_RDREQ,
    output logic                        oIS_THERE_NEW_INSTRUCTION,
    output logic [6:0]                  oSTATE_INSTRUCTION,
    output logic [8*BYTES_PER_WORD-1:0] oWORD,
    output logic                        oWORD_VALID,
    output logic [FIFO_AW:0]            oFIFO_LEVEL,
    output logic                        oOVERFLOW,
    output logic                        oINSTR_LOST
);

    localparam int         WW        = 8 * BYTES_PER_WORD;
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

    inByte_t    inQ;
    logic [6:0] lutCode;
    logic       lutPayload;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            inQ <= '0;
        end else begin
            inQ.valid <= iBYTE_VALID;
            inQ.data  <= iBYTE;
            inQ.idle  <= iDECODER_IDLE_TO_TAKE_COMMAND;
        end
    end

    escaped_stream_decoder_cmd_lut uLut (
        .cmdByte    (inQ.data),
        .instrCode  (lutCode),
        .hasPayload (lutPayload)
    );

    escState_t  escState;
    escState_t  escNext;
    logic       newInstr;
    logic [6:0] newCode;
    logic       payloadEn;
    logic       discard;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            escState <= ESC_CLEAR;
        end else begin
            escState <= escNext;
        end
    end

    always_comb begin
        escNext = escState;
        if (inQ.valid) begin
            if (escState == ESC_ARMED) begin
                escNext = ESC_CLEAR;
            end else if (inQ.data == HOSTCMD_ESCAPE) begin
                escNext = ESC_ARMED;
            end
        end
    end

    // ST_IDLE / ST_ERROR escapes resync the word assembler
    always_comb begin
        newInstr  = 1'b0;
        newCode   = ST_ERROR;
        payloadEn = 1'b0;
        discard   = 1'b0;
        if (inQ.valid) begin
            if (escState == ESC_ARMED) begin
                unique case (inQ.data)
                    ESCAPECMD_IDLE: begin
                        newInstr = 1'b1;
                        newCode  = ST_IDLE;
                        discard  = 1'b1;
                    end
                    ESCAPECMD_ACK: begin
                        newInstr = 1'b1;
                        newCode  = INSTRUCTION_ACK;
                    end
                    ESCAPECMD_LITERAL: payloadEn = 1'b1;
                    default: begin
                        newInstr = 1'b1;
                        newCode  = ST_ERROR;
                        discard  = 1'b1;
                    end
                endcase
            end else if (inQ.data != HOSTCMD_ESCAPE) begin
                if (inQ.idle) begin
                    newInstr  = 1'b1;
                    newCode   = lutCode;
                    payloadEn = lutPayload;
                end else begin
                    payloadEn = 1'b1;
                end
            end
        end
    end

    logic       instrFlag;
    logic [6:0] instrCode;
    logic       instrLost;

    // A fresh instruction beats an ack arriving on the same edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            instrFlag <= 1'b0;
            instrCode <= ST_IDLE;
            instrLost <= 1'b0;
        end else if (newInstr) begin
            instrFlag <= 1'b1;
            instrCode <= newCode;
            if (instrFlag && !iDECODER_ACK_INSTR) begin
                instrLost <= 1'b1;
            end
        end else if (iDECODER_ACK_INSTR) begin
            instrFlag <= 1'b0;
        end
    end

    logic [2:0]    byteCnt;
    logic [WW-1:0] asmWord;
    logic [WW-1:0] asmNext;
    logic          pushReq;
    logic [WW-1:0] pushWord;

    always_comb begin
        asmNext = asmWord;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byteCnt == 3'(i)) begin
                asmNext[8*i +: 8] = inQ.data;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            byteCnt  <= 3'd0;
            asmWord  <= '0;
            pushReq  <= 1'b0;
            pushWord <= '0;
        end else begin
            pushReq <= 1'b0;
            if (discard) begin
                byteCnt <= 3'd0;
            end else if (payloadEn) begin
                asmWord <= asmNext;
                if (byteCnt == LAST_BYTE) begin
                    pushReq  <= 1'b1;
                    pushWord <= asmNext;
                    byteCnt  <= 3'd0;
                end else begin
                    byteCnt <= byteCnt + 3'd1;
                end
            end
        end
    end

    logic [WW-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wrPtr;
    logic [FIFO_AW:0] rdPtr;
    logic           fifoEmpty;
    logic           fifoFull;
    logic           doPop;
    logic           doPush;
    logic           overflow;

    // Extra pointer MSB separates full from empty
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[FIFO_AW] != rdPtr[FIFO_AW]) &&
                       (wrPtr[FIFO_AW-1:0] == rdPtr[FIFO_AW-1:0]);
    assign doPop     = iWORD_RDREQ && !fifoEmpty;
    assign doPush    = pushReq && (!fifoFull || doPop);

    always_ff @(posedge iCLK) begin
        if (doPush) begin
            mem[wrPtr[FIFO_AW-1:0]] <= pushWord;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (pushReq && !doPush) begin
                overflow <= 1'b1;
            end
        end
    end

    assign oIS_THERE_NEW_INSTRUCTION = instrFlag;
    assign oSTATE_INSTRUCTION        = instrCode;
    assign oINSTR_LOST               = instrLost;
    assign oWORD                     = mem[rdPtr[FIFO_AW-1:0]];
    assign oWORD_VALID               = !fifoEmpty;
    assign oFIFO_LEVEL               = wrPtr - rdPtr;
    assign oOVERFLOW                 = overflow;

endmodule
